f_fetch_unit: RTL and testbench

- F-stage producer for the F/D pipeline register: holds the program counter, drives the instruction-memory address, and presents F_PC / F_command to the F/D register.
- Accepts a control-flow redirect from D (branch/jump/jr target, MIPS delay-slot semantics).
- Accepts a stall enable from the hazard unit. A redirect that arrives during a stall is retained, not dropped.

---
 rtl/cpu_defs.sv | 7 +
 rtl/f_npc_sel.sv | 36 +++
 rtl/f_fetch_unit.sv | 60 ++++++
 tb/tb_f_fetch_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Constants shared by the pipeline registers and the instruction memory.
package cpu_defs;
  localparam logic [31:0] PcReset = 32'h0000_3000;
  localparam logic [31:0] Nop     = 32'h0000_0000;
  localparam int unsigned ImAw    = 12;
  localparam int unsigned ImDepth = 1 << ImAw;
endpackage

// File: rtl/f_npc_sel.sv
// Next-PC and pending-redirect selection for the fetch stage; purely combinational.
module f_npc_sel (
  input  logic        i_we,
  input  logic [31:0] i_pc,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  input  logic        i_pend_valid,
  input  logic [31:0] i_pend_target,
  output logic [31:0] o_next_pc,
  output logic        o_next_pend_valid,
  output logic [31:0] o_next_pend_target
);
  logic [31:0] w_target_aligned;

  assign w_target_aligned = i_redirect_target & ~32'd3;

  always_comb begin
    o_next_pc          = i_pc;
    o_next_pend_valid  = i_pend_valid;
    o_next_pend_target = i_pend_target;
    if (i_we) begin
      o_next_pend_valid = 1'b0;
      if (i_redirect_valid) begin
        o_next_pc = w_target_aligned;
      end else if (i_pend_valid) begin
        o_next_pc = i_pend_target;
      end else begin
        o_next_pc = i_pc + 32'd4;
      end
    end else if (i_redirect_valid) begin
      // Latest stalled redirect wins over any older pending one.
      o_next_pend_valid  = 1'b1;
      o_next_pend_target = w_target_aligned;
    end
  end
endmodule

// File: rtl/f_fetch_unit.sv
// F-stage: PC and pending-redirect registers, imem addressing and out-of-range nop insertion.
module f_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] PC_RESET = PcReset,
  parameter int unsigned IM_AW    = ImAw
) (
  input  logic             clk,
  input  logic             res,
  input  logic             F_WE,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic [IM_AW-1:0] imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      F_PC,
  output logic [31:0]      F_command,
  output logic             F_redirect_pending
);
  logic [31:0] r_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic [31:0] w_next_pc;
  logic        w_next_pend_valid;
  logic [31:0] w_next_pend_target;
  logic [31:0] w_off;
  logic        w_in_range;

  f_npc_sel u_npc_sel (
    .i_we               (F_WE),
    .i_pc               (r_pc),
    .i_redirect_valid   (redirect_valid),
    .i_redirect_target  (redirect_target),
    .i_pend_valid       (r_pend_valid),
    .i_pend_target      (r_pend_target),
    .o_next_pc          (w_next_pc),
    .o_next_pend_valid  (w_next_pend_valid),
    .o_next_pend_target (w_next_pend_target)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      r_pc          <= PC_RESET;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'd0;
    end else begin
      r_pc          <= w_next_pc;
      r_pend_valid  <= w_next_pend_valid;
      r_pend_target <= w_next_pend_target;
    end
  end

  // Byte offset must be non-negative and fit in IM_AW word-address bits.
  assign w_off      = r_pc - PC_RESET;
  assign w_in_range = (r_pc >= PC_RESET) && ((w_off >> (IM_AW + 2)) == 32'd0);

  assign imem_addr          = w_off[IM_AW+1:2];
  assign F_command          = w_in_range ? imem_rdata : Nop;
  assign F_PC               = r_pc;
  assign F_redirect_pending = r_pend_valid;
endmodule

// File: tb/tb_f_fetch_unit.sv
// Scoreboard bench for f_fetch_unit: directed plan plus randomized redirect/stall traffic.
module tb_f_fetch_unit;
  typedef struct {
    logic [31:0] pc;
    logic [11:0] addr;
    logic [31:0] cmd;
    logic        pend;
  } exp_t;

  logic        clk = 1'b0;
  logic        res;
  logic        F_WE;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_command;
  logic        F_redirect_pending;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t q[$];

  logic [31:0] m_pc;
  logic        m_pv;
  logic [31:0] m_pt;

  always #5 clk = ~clk;

  f_fetch_unit dut (
    .clk                (clk),
    .res                (res),
    .F_WE               (F_WE),
    .redirect_valid     (redirect_valid),
    .redirect_target    (redirect_target),
    .imem_addr          (imem_addr),
    .imem_rdata         (imem_rdata),
    .F_PC               (F_PC),
    .F_command          (F_command),
    .F_redirect_pending (F_redirect_pending)
  );

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return ({20'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: PC byte address mapped into a 4096-word memory starting at 0x3000.
  function automatic exp_t predict(input logic [31:0] pc, input logic pend);
    exp_t e;
    longint off;
    off    = longint'(pc) - longint'(32'h3000);
    e.pc   = pc;
    e.addr = 12'((pc - 32'h3000) / 4);
    e.cmd  = (off >= 0 && off / 4 < 4096) ? mem_word(e.addr) : 32'h0;
    e.pend = pend;
    return e;
  endfunction

  task automatic cyc(input logic rst, input logic we, input logic rv, input logic [31:0] tgt);
    res = rst; F_WE = we; redirect_valid = rv; redirect_target = tgt;
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h3000; m_pv = 1'b0; m_pt = 32'h0;
    end else if (we) begin
      if (rv) m_pc = {tgt[31:2], 2'b00};
      else if (m_pv) m_pc = m_pt;
      else m_pc = m_pc + 32'd4;
      m_pv = 1'b0;
    end else if (rv) begin
      m_pv = 1'b1; m_pt = {tgt[31:2], 2'b00};
    end
    q.push_back(predict(m_pc, m_pv));
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("F_PC", F_PC, e.pc);
      chk("imem_addr", {20'd0, imem_addr}, {20'd0, e.addr});
      chk("F_command", F_command, e.cmd);
      chk("F_redirect_pending", {31'd0, F_redirect_pending}, {31'd0, e.pend});
    end
  end

  function automatic logic [31:0] rand_target();
    int unsigned pick;
    pick = $urandom_range(0, 9);
    if (pick < 7) return 32'h3000 + ($urandom_range(0, 4095) << 2) + $urandom_range(0, 3);
    if (pick == 7) return $urandom_range(0, 32'h2FFF);
    if (pick == 8) return 32'h7000 + $urandom_range(0, 32'hFFFF);
    return $urandom;
  endfunction

  initial begin
    res = 1'b1; F_WE = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    cyc(1, 1, 0, 0);
    chk("reset_pc", F_PC, 32'h3000);
    chk("reset_addr", {20'd0, imem_addr}, 32'd0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("seq_pc", F_PC, 32'h3008);
    cyc(0, 1, 1, 32'h3103);
    chk("redir_aligned", F_PC, 32'h3100);
    cyc(0, 1, 1, 32'h3010);
    cyc(0, 0, 1, 32'h3200);
    chk("stall_hold", F_PC, 32'h3010);
    chk("stall_pending", {31'd0, F_redirect_pending}, 32'd1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("pend_applied", F_PC, 32'h3200);
    cyc(0, 0, 1, 32'h3200);
    cyc(0, 0, 1, 32'h3300);
    cyc(0, 1, 0, 0);
    chk("pend_overwrite", F_PC, 32'h3300);
    cyc(0, 0, 1, 32'h3200);
    cyc(0, 1, 1, 32'h3400);
    chk("live_beats_pend", F_PC, 32'h3400);
    chk("live_clears_pend", {31'd0, F_redirect_pending}, 32'd0);
    cyc(0, 1, 1, 32'h2FFC);
    chk("below_range_nop", F_command, 32'h0);
    cyc(0, 1, 1, 32'h3000 + 4 * 4096);
    chk("above_range_nop", F_command, 32'h0);
    cyc(0, 1, 1, 32'h6FFC);
    chk("last_word", F_command, mem_word(12'hFFF));
    cyc(0, 1, 1, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0);
    chk("pc_wrap", F_PC, 32'h0);
    cyc(0, 0, 1, 32'h3500);
    cyc(1, 0, 1, 32'h3600);
    chk("reset_over_pend_pc", F_PC, 32'h3000);
    chk("reset_over_pend", {31'd0, F_redirect_pending}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
          rand_target());
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
